// File: rtl/conv_layer_input_interface.sv
// Conv-layer input interface: fills a KxK pixel window from the feature buffer
// and emits one window column per SHIFT. Optional error flag: CONV_INPUT_INTERFACE_ERR_EN.
module conv_layer_input_interface #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_SIZE  = 6,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        input_interface_cmd,
  output logic [1:0]                        input_interface_ack,
  output logic                              rd_en,
  output logic [ADDR_WIDTH-1:0]             rd_addr,
  input  logic [DATA_WIDTH-1:0]             rd_data,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] col_data,
  output logic                              col_valid,
  output logic                              cmd_err
);

  localparam int K    = KERNEL_SIZE;
  localparam int NPRE = K * K;
  localparam int CW   = $clog2(NPRE + 1);
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int RW   = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int NCW  = $clog2(IMAGE_SIZE + 1);

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;

  localparam logic [1:0] ACK_IDLE        = 2'd0;
  localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
  localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
  localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PRELOAD_RD = 2'd1,
    S_LOAD_RD    = 2'd2,
    S_SHIFT_OUT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                  iss_q, pend_q, skip_q, rd_en_q;
  logic [CW-1:0]         iss_cnt_q, cap_cnt_q, total;
  logic [KW-1:0]         iss_col_q, cap_row_q, cap_col_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [RW-1:0]         row_base_q, win_row_q;
  logic [NCW-1:0]        next_col_q;
  logic [1:0]            ack_q, ack_d;
  logic                  col_valid_q, col_valid_d;
  logic [K*DATA_WIDTH-1:0] col_data_q, col_data_d, win_col0;
  logic [DATA_WIDTH-1:0] win_q [K][K];

  logic oor, cap_last, cap_we, shift_go;

  assign oor      = (next_col_q == NCW'(IMAGE_SIZE));
  assign total    = (state_q == S_PRELOAD_RD) ? CW'(NPRE) : CW'(K);
  assign cap_last = pend_q && (cap_cnt_q == total - 1'b1);
  assign cap_we   = pend_q && !skip_q;
  assign shift_go = (state_q == S_SHIFT_OUT);

  for (genvar gi = 0; gi < K; gi++) begin : g_col0
    assign win_col0[gi*DATA_WIDTH +: DATA_WIDTH] = win_q[gi][0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        case (input_interface_cmd)
          CMD_PRELOAD: state_d = S_PRELOAD_RD;
          CMD_SHIFT:   state_d = S_SHIFT_OUT;
          CMD_LOAD:    state_d = S_LOAD_RD;
          default:     state_d = S_IDLE;
        endcase
      end
      S_PRELOAD_RD, S_LOAD_RD: if (cap_last) state_d = S_IDLE;
      S_SHIFT_OUT: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d       = ACK_IDLE;
    col_valid_d = 1'b0;
    col_data_d  = col_data_q;
    unique case (state_q)
      S_PRELOAD_RD: if (cap_last) ack_d = ACK_PRELOAD_FIN;
      S_LOAD_RD:    if (cap_last) ack_d = ACK_LOAD_FIN;
      S_SHIFT_OUT: begin
        ack_d       = ACK_SHIFT_FIN;
        col_valid_d = 1'b1;
        col_data_d  = win_col0;
      end
      default: ;
    endcase
  end

  // Read issue runs one cycle ahead of capture; pend_q marks the cycle rd_data is valid.
  // An out-of-range LOAD still runs the pipeline (skip_q) so its ack latency is unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q       <= ACK_IDLE;
      col_valid_q <= 1'b0;
      col_data_q  <= '0;
      iss_q       <= 1'b0;
      pend_q      <= 1'b0;
      skip_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      iss_cnt_q   <= '0;
      cap_cnt_q   <= '0;
      iss_col_q   <= '0;
      cap_row_q   <= '0;
      cap_col_q   <= '0;
      row_base_q  <= '0;
      win_row_q   <= '0;
      next_col_q  <= '0;
    end else begin
      ack_q       <= ack_d;
      col_valid_q <= col_valid_d;
      col_data_q  <= col_data_d;
      pend_q      <= iss_q;

      if (iss_q) begin
        if (iss_cnt_q == total) begin
          iss_q   <= 1'b0;
          rd_en_q <= 1'b0;
        end else begin
          iss_cnt_q <= iss_cnt_q + 1'b1;
          if (state_q == S_LOAD_RD) begin
            if (!skip_q) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(IMAGE_SIZE);
          end else if (iss_col_q == KW'(K-1)) begin
            iss_col_q <= '0;
            rd_addr_q <= rd_addr_q + ADDR_WIDTH'(IMAGE_SIZE - K + 1);
          end else begin
            iss_col_q <= iss_col_q + 1'b1;
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
      end

      if (pend_q) begin
        cap_cnt_q <= cap_cnt_q + 1'b1;
        if (state_q == S_LOAD_RD || cap_col_q == KW'(K-1)) begin
          cap_col_q <= '0;
          cap_row_q <= cap_row_q + 1'b1;
        end else begin
          cap_col_q <= cap_col_q + 1'b1;
        end
      end

      if (cap_last && state_q == S_PRELOAD_RD) begin
        next_col_q <= NCW'(K);
        row_base_q <= (row_base_q == RW'(IMAGE_SIZE - K)) ? '0 : row_base_q + 1'b1;
      end
      if (cap_last && state_q == S_LOAD_RD && !skip_q)
        next_col_q <= next_col_q + 1'b1;

      if (state_q == S_IDLE && input_interface_cmd == CMD_PRELOAD) begin
        iss_q     <= 1'b1;
        rd_en_q   <= 1'b1;
        skip_q    <= 1'b0;
        rd_addr_q <= ADDR_WIDTH'(row_base_q) * ADDR_WIDTH'(IMAGE_SIZE);
        iss_cnt_q <= CW'(1);
        iss_col_q <= '0;
        cap_cnt_q <= '0;
        cap_row_q <= '0;
        cap_col_q <= '0;
        win_row_q <= row_base_q;
      end else if (state_q == S_IDLE && input_interface_cmd == CMD_LOAD) begin
        iss_q     <= 1'b1;
        rd_en_q   <= !oor;
        skip_q    <= oor;
        if (!oor)
          rd_addr_q <= ADDR_WIDTH'(win_row_q) * ADDR_WIDTH'(IMAGE_SIZE) + ADDR_WIDTH'(next_col_q);
        iss_cnt_q <= CW'(1);
        cap_cnt_q <= '0;
        cap_row_q <= '0;
        cap_col_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_q[r][c] <= '0;
    end else if (cap_we) begin
      if (state_q == S_PRELOAD_RD) begin
        win_q[cap_row_q][cap_col_q] <= rd_data;
      end else begin
        for (int c = 0; c < K-1; c++)
          win_q[cap_row_q][c] <= win_q[cap_row_q][c+1];
        win_q[cap_row_q][K-1] <= rd_data;
      end
    end else if (shift_go) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++)
          win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= win_q[r][0];
      end
    end
  end

`ifdef CONV_INPUT_INTERFACE_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if ((state_q != S_IDLE && input_interface_cmd != CMD_IDLE) ||
             (state_q == S_IDLE && input_interface_cmd == CMD_LOAD && oor))
      err_q <= 1'b1;
  end
  assign cmd_err = err_q;
`else
  assign cmd_err = 1'b0;
`endif

  assign input_interface_ack = ack_q;
  assign rd_en               = rd_en_q;
  assign rd_addr             = rd_addr_q;
  assign col_data            = col_data_q;
  assign col_valid           = col_valid_q;

endmodule
